instr_stream_encoder: RTL and testbench
=======================================

Name: instr_stream_encoder

Overview:
- Encoder counterpart to the core's instruction decode path. Accepts abstract micro-ops (kind, rd, rs1, rs2, imm) over a valid/ready stream and packs each into a 32-bit RV32I word.
- Writes the words sequentially into instruction memory through its write port. This is the program-load path used by the test harness and boot logic before the core is released.
- Covers exactly the instruction subset the core decodes: ADD SUB SLL XOR SRL OR AND ADDI LBU SB BEQ BNE AUIPC LUI JAL JALR.

Parameters:
- ADDR_W, 12, byte-address width of the instruction-memory write port.
- DEPTH, 1024, capacity in 32-bit words; the highest legal word address is base_addr + 4*(DEPTH-1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  one-cycle pulse that begins a load session; honoured only in IDLE.
- base_addr  in  ADDR_W  first byte address; sampled on start; bits [1:0] are ignored (forced 0).
- op_valid  in  1  micro-op valid.
- op_ready  out  1  encoder accepts the op this cycle.
- op_last  in  1  marks the final op of the session.
- op_kind  in  5  micro-op kind, values 0-15 per the package enum; 16-31 are illegal.
- op_rd, op_rs1, op_rs2  in  5 each  register fields.
- op_imm  in  32  signed immediate (byte offset for branches and JAL; upper 20 bits for LUI/AUIPC in imm[31:12]).
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_W  byte address of the write.
- imem_wdata  out  32  encoded instruction word.
- done  out  1  level; session ended cleanly.
- error  out  1  level; session aborted.
- words_written  out  ADDR_W  count of words written in the current or last session.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; op_ready=0; imem_we=0; imem_addr=0; imem_wdata=0; done=0; error=0; words_written=0.
- Reset during LOAD discards the session; the partially written memory contents are not cleared.
- States are IDLE, LOAD, DONE, ERR.
- IDLE:
  - op_ready=0.
  - On start: latch base_addr into the write pointer, clear words_written/done/error, go to LOAD.
- LOAD:
  - op_ready=1 and the block never backpressures.
  - Handshake occurs when op_valid && op_ready. An op accepted at cycle t produces imem_we=1 at t+1, with imem_addr = pointer and imem_wdata = encoded word, both registered.
  - imem_we is 0 in every cycle that does not follow a handshake.
  - Back-to-back accepts give one write per cycle.
  - After each write: pointer += 4 and words_written += 1.
- Accepted op with op_last=1: written normally, then go to DONE (done=1 on the same cycle as the final write).
- Illegal op_kind: no write; go to ERR (error=1 at t+1).
- Overflow: an op accepted when words_written == DEPTH is not written; go to ERR. The pointer never wraps.
- DONE / ERR:
  - op_ready=0; done or error held.
  - start returns to LOAD with a fresh session.
  - start in LOAD is ignored.
- Encoding (fixed RV32I):
  - R-type SUB uses funct7=0100000; all other R-type use 0000000.
  - funct3: ADD/SUB 000, SLL 001, XOR 100, SRL 101, OR 110, AND 111.
  - ADDI: opcode 0010011, funct3 000.
  - LBU: opcode 0000011, funct3 100.
  - SB: opcode 0100011, funct3 000, S-split imm.
  - BEQ/BNE: opcode 1100011, funct3 000/001, B-scramble imm[12:1].
  - AUIPC 0010111 and LUI 0110111: U-type, imm[31:12].
  - JAL: opcode 1101111, J-scramble imm[20:1].
  - JALR: opcode 1100111, funct3 000.
- Fields unused by a format are ignored: rd for S/B, rs2 for I/U/J, and so on. Immediate bits outside the format are silently truncated.

Optional Feature:
- Macro ENC_IMM_CHECK_EN.
- Defined:
  - Range-check op_imm per format: I/S must fit signed 12 bits; B must fit signed 13 bits and be even; J must fit signed 21 bits and be even; U must have imm[11:0]==0.
  - A violation is treated like an illegal kind: no write, go to ERR.
- Undefined: no checks; truncate as above.

Decomposition:
- Package instr_enc_pkg holds:
  - op_kind_e enum (16 kinds);
  - opcode, funct3 and funct7 localparams;
  - enc_state_e.
- Combinational sub-module instr_field_pack (kind, rd, rs1, rs2, imm -> word, illegal, range_err) isolates bit packing from the FSM/pointer logic.

Test Plan:
- Reset, then start with base_addr=0x100; send ADD rd=3 rs1=1 rs2=2 with op_last -> cycle after accept: imem_we=1, addr 0x100, wdata 0x002081B3; done=1; words_written=1.
- Back-to-back SUB x5,x6,x7 then LUI x1,0x12345000 (last) -> writes 0x407302B3 @0x100 and 0x123450B7 @0x104 on consecutive cycles.
- BEQ x1,x2,imm=-8 and JAL x1,imm=2048 -> 0xFE208CE3 and 0x001000EF; JALR x0,x1,0 -> 0x00008067.
- DEPTH=4: send 5 ops with no op_last -> 4 writes at 0x0..0xC, 5th op not written, error=1, done=0, words_written=4.
- op_kind=20 mid-stream -> no write for that op, error=1, op_ready=0; later start -> LOAD, error cleared.
- With ENC_IMM_CHECK_EN: ADDI imm=4096 -> error=1, no write. Without the macro: the same op writes 0x00000013 (truncated, assuming rd=rs1=0).

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared encoding constants, micro-op kinds and FSM states for instr_stream_encoder.
package instr_enc_pkg;

  typedef enum logic [4:0] {
    K_ADD   = 5'd0,  K_SUB  = 5'd1,  K_SLL  = 5'd2,  K_XOR  = 5'd3,
    K_SRL   = 5'd4,  K_OR   = 5'd5,  K_AND  = 5'd6,  K_ADDI = 5'd7,
    K_LBU   = 5'd8,  K_SB   = 5'd9,  K_BEQ  = 5'd10, K_BNE  = 5'd11,
    K_AUIPC = 5'd12, K_LUI  = 5'd13, K_JAL  = 5'd14, K_JALR = 5'd15
  } op_kind_e;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} enc_state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational RV32I bit packer for one micro-op.
// Immediate range checking is compiled in with ENC_IMM_CHECK_EN.
module instr_field_pack
  import instr_enc_pkg::*;
(
  input  logic [4:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        range_err
);

  fmt_e       fmt;
  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;

  always_comb begin
    fmt     = FMT_R;
    opc     = OPC_OP;
    f7      = F7_BASE;
    f3      = F3_ADD;
    illegal = 1'b0;
    case (kind)
      K_ADD:   f3 = F3_ADD;
      K_SUB:   begin f3 = F3_ADD; f7 = F7_SUB; end
      K_SLL:   f3 = F3_SLL;
      K_XOR:   f3 = F3_XOR;
      K_SRL:   f3 = F3_SRL;
      K_OR:    f3 = F3_OR;
      K_AND:   f3 = F3_AND;
      K_ADDI:  begin fmt = FMT_I; opc = OPC_OPIMM; end
      K_LBU:   begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_LBU; end
      K_SB:    begin fmt = FMT_S; opc = OPC_STORE; end
      K_BEQ:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BEQ; end
      K_BNE:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BNE; end
      K_AUIPC: begin fmt = FMT_U; opc = OPC_AUIPC; end
      K_LUI:   begin fmt = FMT_U; opc = OPC_LUI; end
      K_JAL:   begin fmt = FMT_J; opc = OPC_JAL; end
      K_JALR:  begin fmt = FMT_I; opc = OPC_JALR; end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    word = '0;
    case (fmt)
      FMT_R: word = {f7, rs2, rs1, f3, rd, opc};
      FMT_I: word = {imm[11:0], rs1, f3, rd, opc};
      FMT_S: word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      FMT_U: word = {imm[31:12], rd, opc};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
      default: word = '0;
    endcase
  end

`ifdef ENC_IMM_CHECK_EN
  // A value fits N signed bits when everything above bit N-2 is a pure sign extension.
  logic s12, s13, s21;
  assign s12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign s13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign s21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    range_err = 1'b0;
    if (!illegal) begin
      case (fmt)
        FMT_I, FMT_S: range_err = !s12;
        FMT_B:        range_err = !s13 || imm[0];
        FMT_J:        range_err = !s21 || imm[0];
        FMT_U:        range_err = |imm[11:0];
        default:      range_err = 1'b0;
      endcase
    end
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: rtl/instr_stream_encoder.sv
// Micro-op stream to RV32I instruction-memory loader (program-load path).
// Optional immediate range checking: define ENC_IMM_CHECK_EN.
module instr_stream_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_last,
  input  logic [4:0]        op_kind,
  input  logic [4:0]        op_rd,
  input  logic [4:0]        op_rs1,
  input  logic [4:0]        op_rs2,
  input  logic [31:0]       op_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_written
);

  enc_state_e        state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       word;
  logic              illegal;
  logic              range_err;
  logic              accept;
  logic              full;

  instr_field_pack u_pack (
    .kind      (op_kind),
    .rd        (op_rd),
    .rs1       (op_rs1),
    .rs2       (op_rs2),
    .imm       (op_imm),
    .word      (word),
    .illegal   (illegal),
    .range_err (range_err)
  );

  assign accept = op_valid && op_ready;
  assign full   = (words_written == ADDR_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      ptr           <= '0;
      op_ready      <= 1'b0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state         <= S_LOAD;
            ptr           <= {base_addr[ADDR_W-1:2], 2'b00};
            words_written <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            op_ready      <= 1'b1;
          end
        end
        S_LOAD: begin
          if (accept) begin
            // Bad ops and overflow abort without touching memory.
            if (illegal || range_err || full) begin
              state    <= S_ERR;
              error    <= 1'b1;
              op_ready <= 1'b0;
            end else begin
              imem_we       <= 1'b1;
              imem_addr     <= ptr;
              imem_wdata    <= word;
              ptr           <= ptr + ADDR_W'(4);
              words_written <= words_written + ADDR_W'(1);
              if (op_last) begin
                state    <= S_DONE;
                done     <= 1'b1;
                op_ready <= 1'b0;
              end
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          op_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Self-checking bench for instr_stream_encoder: vector table plus hand sequences, write scoreboard.
module tb_instr_stream_encoder;
  import instr_enc_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic              op_last = 1'b0;
  logic [4:0]        op_kind = '0, op_rd = '0, op_rs1 = '0, op_rs2 = '0;
  logic [31:0]       op_imm = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              done, error;
  logic [ADDR_W-1:0] words_written;

  instr_stream_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .op_valid(op_valid), .op_ready(op_ready), .op_last(op_last),
    .op_kind(op_kind), .op_rd(op_rd), .op_rs1(op_rs1), .op_rs2(op_rs2), .op_imm(op_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .done(done), .error(error), .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    logic [4:0]  kind, rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  wr_t  sb[$];
  wr_t  mon_e;
  vec_t vt[16];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_session(input logic [ADDR_W-1:0] b);
    start = 1'b1; base_addr = b;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [4:0] k, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im, input logic last);
    op_valid = 1'b1; op_kind = k; op_rd = d; op_rs1 = s1; op_rs2 = s2; op_imm = im; op_last = last;
    tick();
    op_valid = 1'b0; op_last = 1'b0;
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  function automatic vec_t mk(input op_kind_e k, input int d, input int s1, input int s2,
                              input logic [31:0] im, input logic [31:0] exp);
    vec_t v;
    v.kind = k; v.rd = 5'(d); v.rs1 = 5'(s1); v.rs2 = 5'(s2); v.imm = im; v.exp = exp;
    return v;
  endfunction

  // Every write the DUT makes must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got addr %h data %h want no write", imem_addr, imem_wdata);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
        chk("wr_data", imem_wdata, mon_e.data);
      end
    end
  end

  initial begin
    vt[0]  = mk(K_ADD,   3, 1, 2, 32'd0,        32'h002081B3);
    vt[1]  = mk(K_SUB,   5, 6, 7, 32'd0,        32'h407302B3);
    vt[2]  = mk(K_SLL,   1, 1, 1, 32'd0,        32'h001090B3);
    vt[3]  = mk(K_XOR,   4, 5, 6, 32'd0,        32'h0062C233);
    vt[4]  = mk(K_SRL,   1, 2, 3, 32'd0,        32'h003150B3);
    vt[5]  = mk(K_OR,    2, 3, 4, 32'd0,        32'h0041E133);
    vt[6]  = mk(K_AND,   7, 8, 9, 32'd0,        32'h009473B3);
    vt[7]  = mk(K_ADDI,  1, 2, 0, -32'sd5,      32'hFFB10093);
    vt[8]  = mk(K_LBU,   5, 6, 0, -32'sd1,      32'hFFF34283);
    vt[9]  = mk(K_SB,   31, 1, 2, 32'd8,        32'h00208423);
    vt[10] = mk(K_BEQ,   0, 1, 2, -32'sd8,      32'hFE208CE3);
    vt[11] = mk(K_BNE,   0, 3, 4, 32'd16,       32'h00419863);
    vt[12] = mk(K_AUIPC, 2, 0, 0, 32'hFFFFF000, 32'hFFFFF117);
    vt[13] = mk(K_LUI,   1, 0, 0, 32'h12345000, 32'h123450B7);
    vt[14] = mk(K_JAL,   1, 0, 0, 32'd2048,     32'h001000EF);
    vt[15] = mk(K_JALR,  0, 1, 0, 32'd0,        32'h00008067);

    // Reset state
    repeat (3) tick();
    chk("rst_op_ready", 32'(op_ready), 0);
    chk("rst_imem_we", 32'(imem_we), 0);
    chk("rst_imem_addr", 32'(imem_addr), 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_words", 32'(words_written), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_op_ready", 32'(op_ready), 0);

    // One single-op session per table entry; base low bits must be dropped.
    for (int i = 0; i < 16; i++) begin
      begin_session(ADDR_W'(12'h103 + 16 * i));
      chk("sess_op_ready", 32'(op_ready), 1);
      expect_wr(ADDR_W'(12'h100 + 16 * i), vt[i].exp);
      send(vt[i].kind, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm, 1'b1);
      chk("vec_done", 32'(done), 1);
      chk("vec_words", 32'(words_written), 1);
      chk("vec_op_ready", 32'(op_ready), 0);
    end

    // Back-to-back accepts: one write per cycle.
    begin_session(12'h100);
    expect_wr(12'h100, 32'h407302B3);
    expect_wr(12'h104, 32'h123450B7);
    send(K_SUB, 5, 6, 7, 32'd0, 1'b0);
    chk("b2b_we1", 32'(imem_we), 1);
    send(K_LUI, 1, 0, 0, 32'h12345000, 1'b1);
    chk("b2b_we2", 32'(imem_we), 1);
    chk("b2b_done", 32'(done), 1);
    chk("b2b_words", 32'(words_written), 2);
    tick();
    chk("b2b_we_idle", 32'(imem_we), 0);

    // Overflow: fifth op with DEPTH=4 is dropped and aborts.
    begin_session(12'h000);
    for (int i = 0; i < 4; i++) expect_wr(ADDR_W'(4 * i), 32'h000000B3);
    for (int i = 0; i < 5; i++) send(K_ADD, 1, 0, 0, 32'd0, 1'b0);
    chk("ovf_we", 32'(imem_we), 0);
    chk("ovf_error", 32'(error), 1);
    chk("ovf_done", 32'(done), 0);
    chk("ovf_words", 32'(words_written), 4);
    chk("ovf_op_ready", 32'(op_ready), 0);

    // Illegal kind mid-stream, then a fresh session; start inside LOAD is ignored.
    begin_session(12'h200);
    expect_wr(12'h200, 32'h000000B3);
    send(K_ADD, 1, 0, 0, 32'd0, 1'b0);
    send(5'd20, 1, 2, 3, 32'd0, 1'b0);
    chk("ill_we", 32'(imem_we), 0);
    chk("ill_error", 32'(error), 1);
    chk("ill_op_ready", 32'(op_ready), 0);
    chk("ill_words", 32'(words_written), 1);
    begin_session(12'h300);
    chk("restart_error", 32'(error), 0);
    chk("restart_op_ready", 32'(op_ready), 1);
    chk("restart_words", 32'(words_written), 0);
    expect_wr(12'h300, 32'h000000B3);
    send(K_ADD, 1, 0, 0, 32'd0, 1'b0);
    begin_session(12'h400);
    expect_wr(12'h304, 32'h000000B3);
    send(K_ADD, 1, 0, 0, 32'd0, 1'b1);
    chk("ign_start_done", 32'(done), 1);
    chk("ign_start_words", 32'(words_written), 2);

    // Out-of-range ADDI immediate.
    begin_session(12'h010);
`ifdef ENC_IMM_CHECK_EN
    send(K_ADDI, 0, 0, 0, 32'd4096, 1'b1);
    chk("imm_error", 32'(error), 1);
    chk("imm_words", 32'(words_written), 0);
`else
    expect_wr(12'h010, 32'h00000013);
    send(K_ADDI, 0, 0, 0, 32'd4096, 1'b1);
    chk("imm_done", 32'(done), 1);
    chk("imm_words", 32'(words_written), 1);
`endif

    // Reset during LOAD discards the session.
    begin_session(12'h020);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_op_ready", 32'(op_ready), 0);
    chk("mid_rst_words", 32'(words_written), 0);
    rst_n = 1'b1;

    repeat (2) tick();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
